tick_timer_ctrl: RTL

//  Run-time controller for the board timebase divider: loads a period over a valid/ready

---
 rtl/tick_ctrl_pkg.sv | 26 ++
 rtl/tick_period_counter.sv | 47 ++++
 rtl/tick_timer_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tick_ctrl_pkg.sv
// ============================================================================
// Module  : tick_ctrl_pkg
// Brief   : Shared state encoding and default sizing for the tick timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_ctrl_pkg;

   localparam int TICK_CNT_W          = 27;
   localparam int TICK_DEFAULT_PERIOD = 50_000_000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } tick_state_e;

   function automatic logic state_is_busy(input tick_state_e s);
      return (s == ST_RUN) || (s == ST_PAUSE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_period_counter.sv
// ============================================================================
// Module  : tick_period_counter
// Brief   : Cycle counter that wraps at period-1 and flags the terminal count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_period_counter
   import tick_ctrl_pkg::*;
#(
   parameter int CNT_W = TICK_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   output logic             tc
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // period is never zero here, so period-1 cannot underflow
   always_comb begin
      tc      = enable && (count_q == period - CNT_W'(1));
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (tc) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tick_timer_ctrl.sv
// ============================================================================
// Module  : tick_timer_ctrl
// Brief   : Run-time timebase controller: period/mode handshake, start/pause/
//           stop sequencing, tick pulse and toggling square wave.
//           Define TICK_CTRL_TICKCNT_EN to add the 8-bit tick_count output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer_ctrl
   import tick_ctrl_pkg::*;
#(
   parameter int          CNT_W          = TICK_CNT_W,
   parameter int unsigned DEFAULT_PERIOD = TICK_DEFAULT_PERIOD
) (
   input  logic             clk,
   input  logic             resetSW,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic             cfg_oneshot,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   output logic             tick,
   output logic             outsignal,
   output logic             busy,
   output logic             done
`ifdef TICK_CTRL_TICKCNT_EN
   ,
   output logic [7:0]       tick_count
`endif
);

   localparam logic [CNT_W-1:0] c_default_period =
      (DEFAULT_PERIOD == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_PERIOD);

   tick_state_e      state_q,     state_d;
   logic [CNT_W-1:0] period_q,    period_d;
   logic             oneshot_q,   oneshot_d;
   logic             outsignal_q, outsignal_d;

   logic w_cfg_fire;
   logic w_go;
   logic w_stop;
   logic w_tc;

   tick_period_counter #(
      .CNT_W  (CNT_W)
   ) u_counter (
      .clk    (clk),
      .rst    (resetSW),
      .clear  (w_go | w_stop),
      .enable (state_q == ST_RUN),
      .period (period_q),
      .tc     (w_tc)
   );

   always_comb begin
      w_cfg_fire = cfg_valid && (state_q == ST_IDLE);
      w_go       = start && !stop && (state_q == ST_IDLE);
      // stop is meaningless in IDLE and must not clear a held outsignal there
      w_stop     = stop && (state_q != ST_IDLE);

      tick      = w_tc && !w_stop;
      done      = (state_q == ST_DONE) && !stop;
      busy      = state_is_busy(state_q);
      cfg_ready = (state_q == ST_IDLE);
      outsignal = outsignal_q;

      period_d  = period_q;
      oneshot_d = oneshot_q;
      if (w_cfg_fire) begin
         period_d  = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
         oneshot_d = cfg_oneshot;
      end

      outsignal_d = outsignal_q;
      if (w_stop) begin
         outsignal_d = 1'b0;
      end else if (tick) begin
         outsignal_d = ~outsignal_q;
      end

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_go) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (w_stop)                state_d = ST_IDLE;
            else if (w_tc && oneshot_q) state_d = ST_DONE;
            else if (pause)            state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (w_stop)      state_d = ST_IDLE;
            else if (!pause) state_d = ST_RUN;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge resetSW) begin
      if (resetSW) begin
         state_q     <= ST_IDLE;
         period_q    <= c_default_period;
         oneshot_q   <= 1'b0;
         outsignal_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         oneshot_q   <= oneshot_d;
         outsignal_q <= outsignal_d;
      end
   end

`ifdef TICK_CTRL_TICKCNT_EN
   logic [7:0] tick_count_q;
   logic [7:0] tick_count_d;

   always_comb begin
      tick_count_d = tick_count_q;
      if (w_stop) begin
         tick_count_d = 8'd0;
      end else if (tick) begin
         tick_count_d = tick_count_q + 8'd1;
      end
      tick_count = tick_count_q;
   end

   always_ff @(posedge clk or posedge resetSW) begin
      if (resetSW) begin
         tick_count_q <= 8'd0;
      end else begin
         tick_count_q <= tick_count_d;
      end
   end
`endif

endmodule

`default_nettype wire
